uart_rxd: RTL and testbench

- UART receiver; the receive-side counterpart of uart_txd and configured the same way (sample rate, parity, stop bits).
- Oversamples asynchronous serial input i_rxd on i_uart_clk, reframes start/data/parity/stop bits and pushes each received byte into the RX FIFO with per-byte error flags.
- Sits between the pad and the RX FIFO in the UART top level.

---
 rtl/uart_rxd.sv | 167 ++++++++++++++++
 tb/tb_uart_rxd.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rxd.sv
// ============================================================================
// Module   : uart_rxd
// Brief    : Oversampling UART receiver; reframes start/data/parity/stop bits
//            and writes each byte with error flags into the RX FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rxd #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_uart_clk,
    input  logic       i_rst_n,
    input  logic       i_rxd,
    input  logic       i_enable,
    input  logic [1:0] i_cfg_rxd_sample,
    input  logic [1:0] i_cfg_rxd_parity,
    input  logic       i_cfg_rxd_stop,
    input  logic       i_fifo_notfull,
    output logic       o_fifo_wr,
    output logic [7:0] o_fifo_data,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_overrun_err,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs, rxs_prev;
    logic [1:0]             smp_cfg, par_cfg;
    logic                   stop_cfg;
    logic [4:0]             cnt, half_m1, full_m1;
    logic [3:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_err, frm_err;
    logic                   tick, start_det, finish, par_en;

    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync <= '1;
        else          sync <= {sync[SYNC_STAGES-2:0], i_rxd};
    end

    assign rxs       = sync[SYNC_STAGES-1];
    assign start_det = rxs_prev & ~rxs & i_enable;
    assign par_en    = (par_cfg == 2'b01) || (par_cfg == 2'b10);
    assign o_busy    = (state != IDLE);

    // Counter runs 0..N-1 so that N = 32 still fits in five bits.
    always_comb begin
        case (smp_cfg)
            2'b00:   begin half_m1 = 5'd3;  full_m1 = 5'd7;  end
            2'b10:   begin half_m1 = 5'd15; full_m1 = 5'd31; end
            default: begin half_m1 = 5'd7;  full_m1 = 5'd15; end
        endcase
        tick = (state == START) ? (cnt == half_m1) : (cnt == full_m1);
    end

    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        case (state)
            IDLE:   if (start_det) state_nxt = START;
            START:  if (tick) state_nxt = rxs ? IDLE : DATA;
            DATA:   if (tick && bit_cnt == 4'd7) state_nxt = par_en ? PARITY : STOP1;
            PARITY: if (tick) state_nxt = STOP1;
            STOP1: begin
                if (tick) begin
                    if (stop_cfg) begin
                        state_nxt = STOP2;
                    end else begin
                        state_nxt = IDLE;
                        finish    = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (tick) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && !i_enable) begin
            state_nxt = IDLE;
            finish    = 1'b0;
        end
    end

    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rxs_prev      <= 1'b1;
            smp_cfg       <= 2'b00;
            par_cfg       <= 2'b00;
            stop_cfg      <= 1'b0;
            cnt           <= 5'd0;
            bit_cnt       <= 4'd0;
            shreg         <= 8'h00;
            par_err       <= 1'b0;
            frm_err       <= 1'b0;
            o_fifo_wr     <= 1'b0;
            o_fifo_data   <= 8'h00;
            o_parity_err  <= 1'b0;
            o_frame_err   <= 1'b0;
            o_overrun_err <= 1'b0;
        end else begin
            rxs_prev      <= rxs;
            o_fifo_wr     <= 1'b0;
            o_parity_err  <= 1'b0;
            o_frame_err   <= 1'b0;
            o_overrun_err <= 1'b0;
            if (state == IDLE) begin
                if (start_det) begin
                    smp_cfg  <= i_cfg_rxd_sample;
                    par_cfg  <= i_cfg_rxd_parity;
                    stop_cfg <= i_cfg_rxd_stop;
                    cnt      <= 5'd0;
                    bit_cnt  <= 4'd0;
                    par_err  <= 1'b0;
                    frm_err  <= 1'b0;
                end
            end else begin
                cnt <= tick ? 5'd0 : cnt + 5'd1;
                if (tick) begin
                    case (state)
                        DATA: begin
                            shreg   <= {rxs, shreg[7:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        PARITY:       par_err <= (^shreg) ^ rxs ^ (par_cfg == 2'b01);
                        STOP1, STOP2: if (!rxs) frm_err <= 1'b1;
                        default:      ;
                    endcase
                end
            end
            // The final stop sample is folded in directly; frm_err updates too late.
            if (finish) begin
                if (i_fifo_notfull) begin
                    o_fifo_wr    <= 1'b1;
                    o_fifo_data  <= shreg;
                    o_parity_err <= par_err;
                    o_frame_err  <= frm_err | ~rxs;
                end else begin
                    o_overrun_err <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rxd.sv
// ============================================================================
// Module   : tb_uart_rxd
// Brief    : Scoreboard bench for uart_rxd with directed and random frames.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rxd;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       enable = 1'b1;
    logic [1:0] cfg_sample = 2'b00;
    logic [1:0] cfg_parity = 2'b00;
    logic       cfg_stop = 1'b0;
    logic       notfull = 1'b1;
    logic       fifo_wr, parity_err, frame_err, overrun_err, busy;
    logic [7:0] fifo_data;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    bit     mon_on = 1'b0;

    typedef struct {
        logic [7:0] data;
        bit         perr;
        bit         ferr;
        bit         ovr;
        longint     at;
    } exp_t;

    exp_t q[$];

    uart_rxd #(.SYNC_STAGES(SYNC)) dut (
        .i_uart_clk      (clk),
        .i_rst_n         (rst_n),
        .i_rxd           (rxd),
        .i_enable        (enable),
        .i_cfg_rxd_sample(cfg_sample),
        .i_cfg_rxd_parity(cfg_parity),
        .i_cfg_rxd_stop  (cfg_stop),
        .i_fifo_notfull  (notfull),
        .o_fifo_wr       (fifo_wr),
        .o_fifo_data     (fifo_data),
        .o_parity_err    (parity_err),
        .o_frame_err     (frame_err),
        .o_overrun_err   (overrun_err),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT emits a write or an overrun.
    always @(negedge clk) begin
        if (mon_on) begin
            if (fifo_wr || overrun_err) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output wr=%b ovr=%b data=%h cycle=%0d",
                             fifo_wr, overrun_err, fifo_data, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("write_cycle", cyc, e.at);
                    chk("overrun", overrun_err, e.ovr);
                    chk("fifo_wr", fifo_wr, !e.ovr);
                    if (!e.ovr) begin
                        chk("data", fifo_data, e.data);
                        chk("parity_err", parity_err, e.perr);
                        chk("frame_err", frame_err, e.ferr);
                    end else begin
                        chk("err_flags_on_overrun", {parity_err, frame_err}, 0);
                    end
                end
            end else if (parity_err || frame_err) begin
                chk("stray_err_pulse", {parity_err, frame_err}, 0);
            end
        end
    end

    // kill: 0 none, 1 drop enable, 2 assert reset (at mid of bit kill_bit)
    task automatic send_frame(input logic [7:0] data, input bit bad_par, input int bad_stop,
                              input bit full, input bit scramble, input int kill,
                              input int kill_bit, input int hold_low, input int gap);
        int         n, k;
        bit         pen, odd, ferr;
        logic       bits[$];
        logic       p;
        logic [1:0] s_sample, s_parity;
        logic       s_stop;
        exp_t       e;
        s_sample = cfg_sample;
        s_parity = cfg_parity;
        s_stop   = cfg_stop;
        n   = (cfg_sample == 2'b00) ? 8 : (cfg_sample == 2'b10) ? 32 : 16;
        pen = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
        odd = (cfg_parity == 2'b01);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (pen) begin
            p = (^data) ^ odd;
            if (bad_par) p = ~p;
            bits.push_back(p);
        end
        bits.push_back(bad_stop == 1 ? 1'b0 : 1'b1);
        if (cfg_stop) bits.push_back(bad_stop == 2 ? 1'b0 : 1'b1);
        ferr = (bad_stop == 1) || (bad_stop == 2 && cfg_stop);
        k = bits.size() - 1;
        notfull = !full;
        @(negedge clk);
        e.data = data;
        e.perr = pen && bad_par;
        e.ferr = ferr;
        e.ovr  = full;
        e.at   = cyc + SYNC + n / 2 + n * k + 1;
        if (kill == 0) q.push_back(e);
        for (int b = 0; b < bits.size(); b++) begin
            rxd = bits[b];
            if (b == 1 && scramble) begin
                cfg_sample = 2'($urandom);
                cfg_parity = 2'($urandom);
                cfg_stop   = 1'($urandom);
            end
            for (int c = 0; c < n; c++) begin
                if (kill == 1 && b == kill_bit && c == n / 2) begin
                    enable = 1'b0;
                    @(negedge clk);
                    chk("busy_after_disable", busy, 0);
                end
                if (kill == 2 && b == kill_bit && c == n / 2) begin
                    rst_n = 1'b0;
                    #1;
                    chk("reset_outputs", {fifo_wr, fifo_data, parity_err, frame_err,
                                          overrun_err, busy}, 0);
                end
                @(negedge clk);
            end
        end
        if (kill == 0) chk("busy_after_frame", busy, 0);
        if (hold_low > 0) begin
            rxd = 1'b0;
            repeat (hold_low) @(negedge clk);
            chk("busy_line_stuck_low", busy, 0);
        end
        cfg_sample = s_sample;
        cfg_parity = s_parity;
        cfg_stop   = s_stop;
        rxd     = 1'b1;
        enable  = 1'b1;
        rst_n   = 1'b1;
        notfull = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", {fifo_wr, fifo_data, parity_err, frame_err, overrun_err, busy}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        mon_on = 1'b1;

        // N=8, even parity, 1 stop
        cfg_sample = 2'b00; cfg_parity = 2'b10; cfg_stop = 1'b0;
        send_frame(8'h4B, 0, 0, 0, 0, 0, 0, 0, 4);
        send_frame(8'h4B, 1, 0, 0, 0, 0, 0, 0, 4);
        send_frame(8'h4B, 0, 1, 0, 0, 0, 0, 60, 4);

        // N=16, odd parity, 2 stops, back to back
        cfg_sample = 2'b01; cfg_parity = 2'b01; cfg_stop = 1'b1;
        send_frame(8'hA5, 0, 0, 0, 0, 0, 0, 0, 0);
        send_frame(8'h3C, 0, 0, 0, 0, 0, 0, 0, 4);

        // 3-cycle glitch at N=8
        cfg_sample = 2'b00; cfg_parity = 2'b00; cfg_stop = 1'b0;
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        chk("busy_during_glitch", busy, 1);
        repeat (10) @(negedge clk);
        chk("busy_after_glitch", busy, 0);

        // FIFO full at frame end
        send_frame(8'h96, 0, 0, 1, 0, 0, 0, 0, 4);
        // Enable dropped mid-DATA, then reset mid-frame
        send_frame(8'h5A, 0, 0, 0, 0, 1, 3, 0, 4);
        send_frame(8'hC3, 0, 0, 0, 0, 2, 4, 0, 4);
        send_frame(8'h81, 0, 0, 0, 0, 0, 0, 0, 4);

        // Random frames with mid-frame config scrambling
        for (int r = 0; r < 16; r++) begin
            int bs;
            cfg_sample = 2'($urandom);
            cfg_parity = 2'($urandom);
            cfg_stop   = 1'($urandom);
            bs = ($urandom_range(0, 5) == 0) ? (cfg_stop ? $urandom_range(1, 2) : 1) : 0;
            send_frame(8'($urandom), 1'($urandom), bs, $urandom_range(0, 7) == 0,
                       1'b1, 0, 0, 0, $urandom_range(2, 5));
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
